// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-to-execute pipeline register in front of the ALU.
// It captures the decoded operation with EX/WB-forwarded operands and the
// immediate selection. A held entry snoops WB writes in place.
// Optional build macro ALU_ISSUE_SKID_EN adds a 1-entry skid buffer and
// registers in_ready_o. The default build has no skid, and in_ready_o is
// then combinational.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 6,
  parameter int RAW  = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [OPW-1:0]  ALUop_i,
  input  logic [RAW-1:0]  rs1_addr_i,
  input  logic [RAW-1:0]  rs2_addr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            use_imm_i,
  input  logic [RAW-1:0]  rd_addr_i,
  input  logic            reg_write_i,
  input  logic            ex_wr_en_i,
  input  logic [RAW-1:0]  ex_rd_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic            wb_wr_en_i,
  input  logic [RAW-1:0]  wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [OPW-1:0]  ALUop_o,
  output logic [XLEN-1:0] operand_A_o,
  output logic [XLEN-1:0] operand_B_o,
  output logic [4:0]      shamt_o,
  output logic [RAW-1:0]  rd_addr_o,
  output logic            reg_write_o
);

  // One issued instruction. The source indices and use_imm flag are kept so
  // that a stalled entry can still pick up late WB results.
  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic            use_imm;
    logic [RAW-1:0]  rd;
    logic            rw;
  } entry_t;

  // Bypass resolution for one source. x0 always reads zero, and EX beats WB.
  function automatic logic [XLEN-1:0] fwd(input logic [RAW-1:0]  idx,
                                          input logic [XLEN-1:0] rf_data);
    logic [XLEN-1:0] r;
    if (idx == '0)                          r = '0;
    else if (ex_wr_en_i && ex_rd_i == idx)  r = ex_result_i;
    else if (wb_wr_en_i && wb_rd_i == idx)  r = wb_data_i;
    else                                    r = rf_data;
    return r;
  endfunction

  // A fresh entry built from the decode inputs with forwarding applied.
  function automatic entry_t incoming();
    entry_t e;
    e.op      = ALUop_i;
    e.a       = fwd(rs1_addr_i, rs1_data_i);
    e.b       = use_imm_i ? imm_i : fwd(rs2_addr_i, rs2_data_i);
    e.rs1     = rs1_addr_i;
    e.rs2     = rs2_addr_i;
    e.use_imm = use_imm_i;
    e.rd      = rd_addr_i;
    e.rw      = reg_write_i;
    return e;
  endfunction

  // A waiting entry absorbs a WB write to one of its sources.
  // An immediate operand B is never overwritten.
  function automatic entry_t snoop(input entry_t e);
    entry_t r;
    r = e;
    if (wb_wr_en_i && wb_rd_i != '0) begin
      if (wb_rd_i == e.rs1)                r.a = wb_data_i;
      if (!e.use_imm && wb_rd_i == e.rs2)  r.b = wb_data_i;
    end
    return r;
  endfunction

  logic   valid_q, valid_d;
  entry_t entry_q, entry_d;
  logic   main_free;
  logic   accept;

  assign main_free = !valid_q || out_ready_i;
  assign accept    = in_valid_i && in_ready_o && !flush_i;

`ifdef ALU_ISSUE_SKID_EN
  logic   skid_valid_q, skid_valid_d;
  entry_t skid_q, skid_d;
  logic   ready_q, ready_d;

  assign in_ready_o = ready_q;

  // Next state for the main and skid entries. Flush beats drain, capture and hold.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    valid_d      = valid_q;
    entry_d      = entry_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush_i) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // The skid is full, so in_ready_o is low and nothing new can arrive this cycle.
        valid_d      = 1'b1;
        entry_d      = snoop(skid_q);
        skid_valid_d = 1'b0;
      end else begin
        valid_d = accept;
        if (accept) entry_d = incoming();
      end
    end else begin
      entry_d = snoop(entry_q);
      if (skid_valid_q) begin
        skid_d = snoop(skid_q);
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_d       = incoming();
      end
    end
    ready_d = !skid_valid_d;
  end

  // Skid buffer and registered ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      ready_q      <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      ready_q      <= ready_d;
    end
  end
`else
  assign in_ready_o = main_free;

  // Next state for the main entry. Flush beats capture and hold, and a held entry snoops WB.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (main_free) begin
      valid_d = accept;
      if (accept) entry_d = incoming();
    end else begin
      entry_d = snoop(entry_q);
    end
  end
`endif

  // Main output register. Reset clears the valid bit and all data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the datapath is reset too, not just valid, because every output must read 0 in reset.
    if (!rst_ni) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign out_valid_o = valid_q;
  assign ALUop_o     = entry_q.op;
  assign operand_A_o = entry_q.a;
  assign operand_B_o = entry_q.b;
  assign shamt_o     = entry_q.b[4:0];
  assign rd_addr_o   = entry_q.rd;
  assign reg_write_o = entry_q.rw;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, scoreboard-based bench for alu_issue_stage.
// Expected ALU inputs are queued when an instruction is offered, then compared
// and popped when the stage presents it.
module tb_alu_issue_stage;
  localparam int XLEN = 32;
  localparam int OPW  = 6;
  localparam int RAW  = 5;
`ifdef ALU_ISSUE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [OPW-1:0]  ALUop_i;
  logic [RAW-1:0]  rs1_addr_i, rs2_addr_i;
  logic [XLEN-1:0] rs1_data_i, rs2_data_i;
  logic [XLEN-1:0] imm_i;
  logic            use_imm_i;
  logic [RAW-1:0]  rd_addr_i;
  logic            reg_write_i;
  logic            ex_wr_en_i;
  logic [RAW-1:0]  ex_rd_i;
  logic [XLEN-1:0] ex_result_i;
  logic            wb_wr_en_i;
  logic [RAW-1:0]  wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [OPW-1:0]  ALUop_o;
  logic [XLEN-1:0] operand_A_o, operand_B_o;
  logic [4:0]      shamt_o;
  logic [RAW-1:0]  rd_addr_o;
  logic            reg_write_o;

  always #5 clk_i = ~clk_i;

  alu_issue_stage #(.XLEN(XLEN), .OPW(OPW), .RAW(RAW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ALUop_i(ALUop_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .use_imm_i(use_imm_i),
    .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i),
    .ex_wr_en_i(ex_wr_en_i), .ex_rd_i(ex_rd_i), .ex_result_i(ex_result_i),
    .wb_wr_en_i(wb_wr_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ALUop_o(ALUop_o), .operand_A_o(operand_A_o), .operand_B_o(operand_B_o),
    .shamt_o(shamt_o), .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o)
  );

  typedef struct {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      sh;
    logic [RAW-1:0]  rd;
    logic            rw;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    in_valid_i  = 1'b0;
    ALUop_i     = '0;
    rs1_addr_i  = '0;
    rs2_addr_i  = '0;
    rs1_data_i  = '0;
    rs2_data_i  = '0;
    imm_i       = '0;
    use_imm_i   = 1'b0;
    rd_addr_i   = '0;
    reg_write_i = 1'b0;
    ex_wr_en_i  = 1'b0;
    ex_rd_i     = '0;
    ex_result_i = '0;
    wb_wr_en_i  = 1'b0;
    wb_rd_i     = '0;
    wb_data_i   = '0;
    flush_i     = 1'b0;
  endtask

  task automatic issue(input logic [OPW-1:0] op,
                       input logic [RAW-1:0] r1, input logic [XLEN-1:0] d1,
                       input logic [RAW-1:0] r2, input logic [XLEN-1:0] d2,
                       input logic [XLEN-1:0] imm, input logic ui,
                       input logic [RAW-1:0] rd, input logic rw);
    in_valid_i  = 1'b1;
    ALUop_i     = op;
    rs1_addr_i  = r1;
    rs1_data_i  = d1;
    rs2_addr_i  = r2;
    rs2_data_i  = d2;
    imm_i       = imm;
    use_imm_i   = ui;
    rd_addr_i   = rd;
    reg_write_i = rw;
  endtask

  task automatic push(input logic [OPW-1:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [4:0] sh,
                      input logic [RAW-1:0] rd, input logic rw);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.sh = sh; e.rd = rd; e.rw = rw;
    sb.push_back(e);
  endtask

  task automatic check_head(input string tag);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected a queued entry", tag);
    end else begin
      chk({tag, ".valid"}, 32'(out_valid_o), 32'd1);
      chk({tag, ".op"},    32'(ALUop_o),     32'(sb[0].op));
      chk({tag, ".a"},     operand_A_o,      sb[0].a);
      chk({tag, ".b"},     operand_B_o,      sb[0].b);
      chk({tag, ".shamt"}, 32'(shamt_o),     32'(sb[0].sh));
      chk({tag, ".rd"},    32'(rd_addr_o),   32'(sb[0].rd));
      chk({tag, ".rw"},    32'(reg_write_o), 32'(sb[0].rw));
    end
  endtask

  task automatic pop();
    if (sb.size() > 0) sb.delete(0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, ".op"},    32'(ALUop_o),     32'd0);
    chk({tag, ".a"},     operand_A_o,      32'd0);
    chk({tag, ".b"},     operand_B_o,      32'd0);
    chk({tag, ".shamt"}, 32'(shamt_o),     32'd0);
    chk({tag, ".rd"},    32'(rd_addr_o),   32'd0);
    chk({tag, ".rw"},    32'(reg_write_o), 32'd0);
    chk({tag, ".ready"}, 32'(in_ready_o),  32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    rst_ni      = 1'b0;
    out_ready_i = 1'b1;
    idle();
    repeat (3) step();
    check_zero("reset");
    rst_ni = 1'b1;
    step();

    // Basic issue, then back-to-back accepts while out_ready_i is high
    issue(6'h00, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1);
    push(6'h00, 32'd5, 32'd7, 5'd7, 5'd3, 1'b1);
    step();
    check_head("basic");
    pop();

    // Immediate selection and x0 ignoring an EX bypass to r0
    issue(6'h0A, 5'd0, 32'd9, 5'd5, 32'h123, 32'hFFFF_FFF0, 1'b1, 5'd4, 1'b1);
    ex_wr_en_i = 1'b1; ex_rd_i = 5'd0; ex_result_i = 32'd3;
    push(6'h0A, 32'd0, 32'hFFFF_FFF0, 5'h10, 5'd4, 1'b1);
    step();
    check_head("imm_x0");
    pop();

    // EX beats WB
    issue(6'h03, 5'd4, 32'h11, 5'd0, 32'h55, 32'd0, 1'b0, 5'd9, 1'b1);
    ex_wr_en_i = 1'b1; ex_rd_i = 5'd4; ex_result_i = 32'hAA;
    wb_wr_en_i = 1'b1; wb_rd_i = 5'd4; wb_data_i   = 32'hBB;
    push(6'h03, 32'hAA, 32'd0, 5'd0, 5'd9, 1'b1);
    step();
    check_head("fwd_ex");
    pop();

    // WB forwarding once EX is disabled, applied to both sources
    issue(6'h04, 5'd4, 32'h11, 5'd4, 32'h44, 32'd0, 1'b0, 5'd9, 1'b1);
    ex_wr_en_i = 1'b0;
    push(6'h04, 32'hBB, 32'hBB, 5'h1B, 5'd9, 1'b1);
    step();
    check_head("fwd_wb");
    pop();

    // Unmatched rs1 reads the register file, and EX supplies rs2
    issue(6'h3F, 5'd7, 32'h77, 5'd5, 32'h66, 32'd0, 1'b0, 5'd0, 1'b0);
    ex_wr_en_i = 1'b1; ex_rd_i = 5'd5; ex_result_i = 32'hEE;
    push(6'h3F, 32'h77, 32'hEE, 5'h0E, 5'd0, 1'b0);
    step();
    check_head("fwd_mix");
    pop();

    // Consume without refill
    idle();
    step();
    chk("drain.valid", 32'(out_valid_o), 32'd0);
    chk("drain.ready", 32'(in_ready_o),  32'd1);

    // Stall with WB snoop of rs2 on the second held cycle
    issue(6'h11, 5'd8, 32'h8, 5'd6, 32'h1, 32'd0, 1'b0, 5'd10, 1'b1);
    push(6'h11, 32'h8, 32'h1, 5'h01, 5'd10, 1'b1);
    step();
    idle();
    out_ready_i = 1'b0;
    #1;
    check_head("stall0");
    chk("stall0.ready", 32'(in_ready_o), 32'(SKID));
    step();
    check_head("stall1");
    chk("stall1.ready", 32'(in_ready_o), 32'(SKID));
    wb_wr_en_i = 1'b1; wb_rd_i = 5'd6; wb_data_i = 32'h22;
    step();
    wb_wr_en_i = 1'b0;
    sb[0].b  = 32'h22;
    sb[0].sh = 5'h02;
    check_head("stall2");
    chk("stall2.ready", 32'(in_ready_o), 32'(SKID));
    step();
    check_head("stall3");
    chk("stall3.ready", 32'(in_ready_o), 32'(SKID));
    out_ready_i = 1'b1;
    #1;
    chk("release.ready", 32'(in_ready_o), 32'd1);
    step();
    pop();
    chk("release.valid", 32'(out_valid_o), 32'd0);

    // A held immediate entry: WB updates A but leaves the immediate B alone.
    // A flush then beats the hold.
    issue(6'h21, 5'd6, 32'h1, 5'd6, 32'h2, 32'h40, 1'b1, 5'd2, 1'b1);
    push(6'h21, 32'h1, 32'h40, 5'h00, 5'd2, 1'b1);
    step();
    idle();
    out_ready_i = 1'b0;
    #1;
    check_head("imm_hold");
    wb_wr_en_i = 1'b1; wb_rd_i = 5'd6; wb_data_i = 32'h99;
    step();
    wb_wr_en_i = 1'b0;
    sb[0].a = 32'h99;
    check_head("imm_snoop");
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    pop();
    chk("flush_hold.valid", 32'(out_valid_o), 32'd0);

    // Flush beats a capture that would otherwise be accepted
    out_ready_i = 1'b1;
    issue(6'h05, 5'd1, 32'h101, 5'd2, 32'h202, 32'd0, 1'b0, 5'd1, 1'b1);
    push(6'h05, 32'h101, 32'h202, 5'h02, 5'd1, 1'b1);
    step();
    check_head("pre_flush");
    pop();
    issue(6'h06, 5'd3, 32'h303, 5'd4, 32'h404, 32'd0, 1'b0, 5'd7, 1'b1);
    flush_i = 1'b1;
    #1;
    chk("flush.ready", 32'(in_ready_o), 32'd1);
    step();
    idle();
    chk("flush_cap.valid", 32'(out_valid_o), 32'd0);
    step();
    chk("flush_drop.valid", 32'(out_valid_o), 32'd0);

    // Normal issue after the flush
    issue(6'h07, 5'd9, 32'h909, 5'd11, 32'h0B1F, 32'd0, 1'b0, 5'd12, 1'b0);
    push(6'h07, 32'h909, 32'h0B1F, 5'h1F, 5'd12, 1'b0);
    step();
    idle();
    check_head("post_flush");
    pop();

    // Async reset in the middle of a stall, between clock edges
    issue(6'h2A, 5'd13, 32'hDEAD_BEEF, 5'd14, 32'h1234_5678, 32'd0, 1'b0, 5'd15, 1'b1);
    push(6'h2A, 32'hDEAD_BEEF, 32'h1234_5678, 5'h18, 5'd15, 1'b1);
    step();
    idle();
    out_ready_i = 1'b0;
    #1;
    check_head("pre_arst");
    pop();
    #1;
    rst_ni = 1'b0;
    #1;
    out_ready_i = 1'b1;
    #1;
    check_zero("arst");
    step();
    rst_ni = 1'b1;
    step();
    chk("post_arst.valid", 32'(out_valid_o), 32'd0);
    chk("post_arst.ready", 32'(in_ready_o),  32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the ALU.
- Captures the decoded ALU operation, register operands and immediate, then resolves EX/WB forwarding and immediate selection.
- Drives ALUop, operand_A, operand_B and shamt to the ALU from registers.
- Uses a valid/ready handshake with stall, flush and in-place WB snooping of a held entry.

Parameters:
- XLEN, 32, datapath width.
- OPW, 6, ALU opcode width.
- RAW, 5, register address width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous reset, active low.
- in_valid_i  input  1  decode offers an instruction.
- in_ready_o  output  1  stage can accept.
- ALUop_i  input  OPW  decoded ALU operation.
- rs1_addr_i, rs2_addr_i  input  RAW  source register indices.
- rs1_data_i, rs2_data_i  input  XLEN  register-file read data.
- imm_i  input  XLEN  sign-extended immediate.
- use_imm_i  input  1  1: operand_B = imm_i.
- rd_addr_i  input  RAW  destination register.
- reg_write_i  input  1  instruction writes rd.
- ex_wr_en_i, ex_rd_i, ex_result_i  input  1/RAW/XLEN  EX-stage bypass.
- wb_wr_en_i, wb_rd_i, wb_data_i  input  1/RAW/XLEN  WB-stage bypass.
- flush_i  input  1  kill held and incoming entries.
- out_valid_o  output  1  ALU inputs valid.
- out_ready_i  input  1  execute consumes.
- ALUop_o  output  OPW  to ALU.
- operand_A_o  output  XLEN  to ALU.
- operand_B_o  output  XLEN  to ALU.
- shamt_o  output  5  to ALU.
- rd_addr_o  output  RAW  destination register, passed through.
- reg_write_o  output  1  write enable, passed through.

Behaviour:
- Reset (rst_ni low, asynchronous): every registered output is 0. This covers out_valid_o, ALUop_o, operand_A_o, operand_B_o, shamt_o, rd_addr_o and reg_write_o. in_ready_o = 1 after reset.
- Accept: a transfer happens when in_valid_i && in_ready_o at a rising edge. Latency is 1 cycle: out_valid_o rises the following cycle.
- in_ready_o = !out_valid_o || out_ready_i. Back-to-back accept is allowed every cycle while out_ready_i = 1.
- Forwarding, per source at capture:
  - If the source index is 0, use 0 regardless of any bypass.
  - Else if ex_wr_en_i && ex_rd_i == index, use ex_result_i.
  - Else if wb_wr_en_i && wb_rd_i == index, use wb_data_i.
  - Else use the register-file data.
  - EX has priority over WB.
- operand_B_o = use_imm_i ? imm_i : forwarded rs2.
- shamt_o = operand_B[4:0] of the selected value.
- Hold: when out_valid_o && !out_ready_i, all outputs hold. The entry keeps rs1/rs2 indices and a use_imm flag internally.
- WB snoop while held: if wb_wr_en_i && wb_rd_i != 0 && wb_rd_i matches a held source index, that operand is updated with wb_data_i.
  - operand_B is not updated when use_imm is set.
  - shamt_o is updated with operand_B.
- Consume without refill: out_valid_o falls next cycle. Data outputs keep their last values and are don't-care.
- Flush: flush_i = 1 clears out_valid_o at the next edge. Flush has priority over both capture and hold. in_valid_i in the same cycle is dropped. in_ready_o is unaffected by flush_i.
- Reset mid-operation: any held entry is discarded immediately. No partial output.
- Operands pass through unmodified: no arithmetic and no width change.

Optional Feature:
- Macro: ALU_ISSUE_SKID_EN.
- With the macro defined, a 1-entry skid buffer is added and in_ready_o is registered: in_ready_o = skid empty.
  - When the main register is stalled and an input arrives, the input is captured into the skid with forwarding resolved.
  - The skid entry also snoops WB.
  - When the main register drains, the skid moves to the output next cycle.
  - Flush clears both entries.
  - Reset value of in_ready_o is 1.
- Without the macro, in_ready_o is combinational from out_ready_i as specified above.

Test Plan:
- Reset then basic issue: rst_ni=0→1; present ALUop=6'h00, rs1 data 5, rs2 data 7, out_ready=1 → next cycle out_valid=1, operand_A=5, operand_B=7, shamt=7.
- Immediate and x0: use_imm=1, imm=32'hFFFF_FFF0, rs1_addr=0 with rs1_data=9 and ex_rd=0 writing 3 → operand_A=0, operand_B=32'hFFFF_FFF0, shamt=5'h10.
- Forward priority: rs1_addr=4; EX writes 4 with 0xAA; WB writes 4 with 0xBB; register file returns 0x11 → operand_A=0xAA. With EX disabled → 0xBB.
- Stall plus snoop: capture rs2_addr=6 as 0x1; hold out_ready=0 for 3 cycles; on cycle 2 WB writes r6=0x22 → outputs stay valid, operand_B becomes 0x22 and shamt 5'h02. in_ready=0 throughout (macro off).
- Flush priority: held valid entry, flush_i=1 together with in_valid_i=1 → next cycle out_valid=0 and no entry is captured. Subsequent input issues normally.
- Async reset mid-stall: rst_ni pulsed low between clock edges while out_valid=1 → out_valid=0 and all outputs 0 immediately, without waiting for a clock edge.
